shift_arbiter: RTL and testbench

Two-port arbiter and pipeline controller that shares a single 32-bit barrel-shift datapath (logical left and arithmetic right) between two requesters, e.g. the execute-stage ALU and a multiply/divide sequencer. Grants one request per cycle under round-robin fairness, registers operands and results in a two-stage pipeline, and returns each result to the originating port with fixed latency.

---
 rtl/shift_arbiter.sv | 97 +++++++++
 tb/tb_shift_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit SLL/SRA barrel shifter between two ports.
// Two register stages (operands, result) give a fixed two-cycle response latency.
module shift_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [4:0]  shamt0,
  input  logic        op0,
  output logic        ready0,
  output logic        resp_valid0,
  output logic [31:0] resp_data0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [4:0]  shamt1,
  input  logic        op1,
  output logic        ready1,
  output logic        resp_valid1,
  output logic [31:0] resp_data1
);

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  function automatic logic signed [DATA_W-1:0] barrel_shift(
    input logic signed [DATA_W-1:0] d,
    input logic [SHAMT_W-1:0]       sh,
    input logic                     sra
  );
    barrel_shift = sra ? (d >>> sh) : (d << sh);
  endfunction

  logic                      last;
  logic                      grant0, grant1, xfer;

  logic signed [DATA_W-1:0]  data_p1;
  logic [SHAMT_W-1:0]        shamt_p1;
  logic                      op_p1, tag_p1, vld_p1;

  logic signed [DATA_W-1:0]  result_p2;
  logic                      tag_p2, vld_p2;

  // last == 1 means port 1 was granted most recently, so port 0 wins contention.
  always_comb begin
    grant0 = ~reset & req0 & (~req1 | last);
    grant1 = ~reset & req1 & (~req0 | ~last);
    xfer   = grant0 | grant1;
  end

  assign ready0 = grant0;
  assign ready1 = grant1;

  always_ff @(posedge clock) begin
    if (reset)
      last <= 1'b1;
    else if (xfer)
      last <= grant1;
  end

  // Stage 1: capture granted operands
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      shamt_p1 <= '0;
      op_p1    <= 1'b0;
      tag_p1   <= 1'b0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1  <= grant1 ? $signed(data1) : $signed(data0);
        shamt_p1 <= grant1 ? shamt1 : shamt0;
        op_p1    <= grant1 ? op1 : op0;
        tag_p1   <= grant1;
      end
    end
  end

  // Stage 2: shift result and routing tag
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      tag_p2    <= 1'b0;
      result_p2 <= '0;
    end else begin
      vld_p2    <= vld_p1;
      tag_p2    <= tag_p1;
      result_p2 <= barrel_shift(data_p1, shamt_p1, op_p1);
    end
  end

  assign resp_valid0 = vld_p2 & ~tag_p2;
  assign resp_valid1 = vld_p2 & tag_p2;
  assign resp_data0  = result_p2;
  assign resp_data1  = result_p2;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: arbitration order, shift results, latency and reset.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, op0, req1, op1;
  logic [31:0] data0, data1;
  logic [4:0]  shamt0, shamt1;
  logic        ready0, ready1, resp_valid0, resp_valid1;
  logic [31:0] resp_data0, resp_data1;

  int vectors = 0;
  int miscompares = 0;

  shift_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .data0(data0), .shamt0(shamt0), .op0(op0),
    .ready0(ready0), .resp_valid0(resp_valid0), .resp_data0(resp_data0),
    .req1(req1), .data1(data1), .shamt1(shamt1), .op1(op1),
    .ready1(ready1), .resp_valid1(resp_valid1), .resp_data1(resp_data1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic [31:0] d, input logic [4:0] s, input logic o);
    req0 = r; data0 = d; shamt0 = s; op0 = o;
  endtask

  task automatic drv1(input logic r, input logic [31:0] d, input logic [4:0] s, input logic o);
    req1 = r; data1 = d; shamt1 = s; op1 = o;
  endtask

  // Advance to just after the next rising edge (start of next cycle).
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rv0"}, resp_valid0, 0);
    chk({tag, "_rv1"}, resp_valid1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv0(1, 32'hFFFF_FFFF, 5'd3, 0);
    drv1(1, 32'h1234_5678, 5'd3, 1);
    next_cycle();
    next_cycle();
    mid();
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);
    chk_quiet("rst");
    chk("rst_rd0", resp_data0, 0);
    chk("rst_rd1", resp_data1, 0);
    next_cycle();
    reset = 1'b0;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    mid();
    chk("idle_ready0", ready0, 0);
    chk("idle_ready1", ready1, 0);

    // Single port 0 SLL
    next_cycle();
    drv0(1, 32'h0000_00F1, 5'd4, 0);
    mid();
    chk("sp_ready0", ready0, 1);
    chk("sp_ready1", ready1, 0);
    next_cycle();
    drv0(0, 0, 0, 0);
    mid();
    chk_quiet("sp_n1");
    next_cycle();
    mid();
    chk("sp_rv0", resp_valid0, 1);
    chk("sp_rd0", resp_data0, 32'h0000_0F10);
    chk("sp_rv1", resp_valid1, 0);
    next_cycle();
    mid();
    chk_quiet("sp_n3");

    // SRA sign fill on port 1, then shamt 0 back-to-back
    next_cycle();
    drv1(1, 32'h8000_0000, 5'd31, 1);
    mid();
    chk("sra_ready1", ready1, 1);
    next_cycle();
    drv1(1, 32'h8000_0000, 5'd0, 1);
    mid();
    chk("sra0_ready1", ready1, 1);
    next_cycle();
    drv1(0, 0, 0, 0);
    mid();
    chk("sra_rv1", resp_valid1, 1);
    chk("sra_rd1", resp_data1, 32'hFFFF_FFFF);
    chk("sra_rv0", resp_valid0, 0);
    next_cycle();
    mid();
    chk("sra0_rv1", resp_valid1, 1);
    chk("sra0_rd1", resp_data1, 32'h8000_0000);
    next_cycle();
    mid();
    chk_quiet("sra_n4");

    // Edge shifts: SLL by 31, SRA of positive by 31
    next_cycle();
    drv0(1, 32'h0000_0003, 5'd31, 0);
    mid();
    chk("edge_ready0", ready0, 1);
    next_cycle();
    drv0(0, 0, 0, 0);
    drv1(1, 32'h7FFF_FFFF, 5'd31, 1);
    mid();
    chk("edge_ready1", ready1, 1);
    next_cycle();
    drv1(0, 0, 0, 0);
    mid();
    chk("edge_sll_rv0", resp_valid0, 1);
    chk("edge_sll_rd0", resp_data0, 32'h8000_0000);
    next_cycle();
    mid();
    chk("edge_sra_rv1", resp_valid1, 1);
    chk("edge_sra_rd1", resp_data1, 32'h0000_0000);

    // Contention after reset: grants 0,1,0,1
    next_cycle();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin drv0(1, 32'h0000_00F1, 5'd4, 0);  drv1(1, 32'h8765_4321, 5'd4, 1);  end
        1: begin drv0(1, 32'h1234_5678, 5'd8, 0);  drv1(1, 32'h8765_4321, 5'd4, 1);  end
        2: begin drv0(1, 32'h1234_5678, 5'd8, 0);  drv1(1, 32'h7000_0000, 5'd28, 1); end
        3: begin drv0(0, 0, 0, 0);                 drv1(1, 32'h7000_0000, 5'd28, 1); end
        default: begin drv0(0, 0, 0, 0);           drv1(0, 0, 0, 0);                 end
      endcase
      mid();
      if (c < 4) begin
        chk($sformatf("cont_ready0_c%0d", c), ready0, (c % 2 == 0) ? 1 : 0);
        chk($sformatf("cont_ready1_c%0d", c), ready1, (c % 2 == 1) ? 1 : 0);
      end
      case (c)
        2: begin chk("cont_rv0_c2", resp_valid0, 1); chk("cont_rv1_c2", resp_valid1, 0);
                 chk("cont_rd0_c2", resp_data0, 32'h0000_0F10); end
        3: begin chk("cont_rv1_c3", resp_valid1, 1); chk("cont_rv0_c3", resp_valid0, 0);
                 chk("cont_rd1_c3", resp_data1, 32'hF876_5432); end
        4: begin chk("cont_rv0_c4", resp_valid0, 1); chk("cont_rv1_c4", resp_valid1, 0);
                 chk("cont_rd0_c4", resp_data0, 32'h3456_7800); end
        5: begin chk("cont_rv1_c5", resp_valid1, 1); chk("cont_rv0_c5", resp_valid0, 0);
                 chk("cont_rd1_c5", resp_data1, 32'h0000_0007); end
        default: chk_quiet($sformatf("cont_c%0d", c));
      endcase
      next_cycle();
    end

    // Sustained port 1 requester: 3 << c for c = 0..4
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drv1(1, 32'h0000_0003, 5'(c), 0);
      else       drv1(0, 0, 0, 0);
      mid();
      if (c < 5) begin
        chk($sformatf("sus_ready1_c%0d", c), ready1, 1);
        chk($sformatf("sus_ready0_c%0d", c), ready0, 0);
      end
      case (c)
        2: begin chk("sus_rv1_c2", resp_valid1, 1); chk("sus_rd1_c2", resp_data1, 32'd3);  end
        3: begin chk("sus_rv1_c3", resp_valid1, 1); chk("sus_rd1_c3", resp_data1, 32'd6);  end
        4: begin chk("sus_rv1_c4", resp_valid1, 1); chk("sus_rd1_c4", resp_data1, 32'd12); end
        5: begin chk("sus_rv1_c5", resp_valid1, 1); chk("sus_rd1_c5", resp_data1, 32'd24); end
        6: begin chk("sus_rv1_c6", resp_valid1, 1); chk("sus_rd1_c6", resp_data1, 32'd48); end
        default: chk_quiet($sformatf("sus_c%0d", c));
      endcase
      next_cycle();
    end

    // Reset mid-flight
    drv0(1, 32'h0000_00FF, 5'd1, 0);
    mid();
    chk("rmf_ready0", ready0, 1);
    next_cycle();
    drv0(0, 0, 0, 0);
    drv1(1, 32'h0000_0001, 5'd1, 0);
    reset = 1'b1;
    mid();
    chk("rmf_ready1", ready1, 0);
    chk("rmf_ready0_n1", ready0, 0);
    next_cycle();
    reset = 1'b0;
    drv1(0, 0, 0, 0);
    mid();
    chk_quiet("rmf_n2");
    chk("rmf_rd0_n2", resp_data0, 0);
    chk("rmf_rd1_n2", resp_data1, 0);
    next_cycle();
    mid();
    chk_quiet("rmf_n3");
    next_cycle();

    // Withdrawn request: port 0 wins, port 1 withdraws, next contention goes to port 1
    drv0(1, 32'h0000_0005, 5'd2, 0);
    drv1(1, 32'hDEAD_BEEF, 5'd3, 1);
    mid();
    chk("wd_ready0", ready0, 1);
    chk("wd_ready1", ready1, 0);
    next_cycle();
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    mid();
    chk_quiet("wd_n1");
    next_cycle();
    mid();
    chk("wd_rv0", resp_valid0, 1);
    chk("wd_rd0", resp_data0, 32'h0000_0014);
    chk("wd_rv1_n2", resp_valid1, 0);
    next_cycle();
    drv0(1, 32'h0000_0001, 5'd1, 0);
    drv1(1, 32'h8000_00F0, 5'd4, 1);
    mid();
    chk_quiet("wd_n3");
    chk("wd2_ready1", ready1, 1);
    chk("wd2_ready0", ready0, 0);
    next_cycle();
    drv1(0, 0, 0, 0);
    mid();
    chk("wd3_ready0", ready0, 1);
    next_cycle();
    drv0(0, 0, 0, 0);
    mid();
    chk("wd2_rv1", resp_valid1, 1);
    chk("wd2_rd1", resp_data1, 32'hF800_000F);
    next_cycle();
    mid();
    chk("wd3_rv0", resp_valid0, 1);
    chk("wd3_rd0", resp_data0, 32'h0000_0002);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
